poly_add_ctrl: RTL and testbench

Sequencer for element-wise NewHope polynomial addition mod q.
- Streams N coefficient pairs out of two synchronous-read coefficient RAMs (A and B), adds each pair mod q, and writes the results to a destination RAM port.
- Sits between the top-level crypto FSM, which drives start/done, and the polynomial BRAMs.
- Destination may alias RAM A (in-place add): the write address always lags the read address.

---
 rtl/newhope_pkg.sv | 16 +
 rtl/poly_add_ctrl_mod_q_add.sv | 24 ++
 rtl/poly_add_ctrl.sv | 127 ++++++++++++
 tb/tb_poly_add_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/newhope_pkg.sv
// Shared NewHope constants and the polynomial-sequencer FSM state type.
// Imported by the coefficient-add datapath and its controller.
package newhope_pkg;

   localparam int NEWHOPE_N  = 1024;
   localparam int NEWHOPE_Q  = 12289;
   localparam int NEWHOPE_AW = 10;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/poly_add_ctrl_mod_q_add.sv
// Purpose: (a + b) mod q with a single conditional subtraction.
// Latency: combinational. Backpressure: none, pure function of inputs.
module mod_q_add
   import newhope_pkg::*;
#(
   parameter int Q = NEWHOPE_Q
) (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] s
);

   logic [16:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   // Operands >= q are not fully reduced; only one subtraction is applied.
   always_comb begin
      s = sum[15:0];
      if (sum >= 17'(Q))
         s = 16'(sum - 17'(Q));
   end

endmodule

// File: rtl/poly_add_ctrl.sv
// Purpose: stream N coefficient pairs from RAMs A/B, add mod q, write to destination.
// Latency: write k on cycle 1+RD_LAT+k after start (+1 with POLY_ADD_OUT_REG_EN); no backpressure.
// Backpressure: none; RAMs must accept one read and one write per cycle.
module poly_add_ctrl
   import newhope_pkg::*;
#(
   parameter int N      = NEWHOPE_N,
   parameter int Q      = NEWHOPE_Q,
   parameter int AW     = NEWHOPE_AW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_addr,
   output logic          rd_en,
   input  logic [15:0]   dia,
   input  logic [15:0]   dib,
   output logic [AW-1:0] wr_addr,
   output logic          wr_en,
   output logic [15:0]   dout
);

   state_t          state;
   logic [RD_LAT-1:0] vld_d;
   logic [AW-1:0]   addr_d [RD_LAT];
   logic [15:0]     sum;
   logic            wv;
   logic [AW-1:0]   wa;
   logic            last;

   mod_q_add #(.Q(Q)) u_add (
      .a (dia),
      .b (dib),
      .s (sum)
   );

   // Valid/address travel alongside the RAM read so they line up with dia/dib.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_d <= '0;
         for (int i = 0; i < RD_LAT; i++)
            addr_d[i] <= '0;
      end else begin
         vld_d[0]  <= rd_en;
         addr_d[0] <= rd_addr;
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_d[i]  <= vld_d[i-1];
            addr_d[i] <= addr_d[i-1];
         end
      end
   end

   assign wv = vld_d[RD_LAT-1];
   assign wa = addr_d[RD_LAT-1];

`ifdef POLY_ADD_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         dout    <= '0;
      end else begin
         wr_en   <= wv;
         wr_addr <= wv ? wa : '0;
         dout    <= wv ? sum : '0;
      end
   end

   assign last = wr_en && !(|vld_d);
`else
   localparam logic [RD_LAT-1:0] TAIL = RD_LAT'(1) << (RD_LAT - 1);
   logic early;

   assign early   = |(vld_d & ~TAIL);
   assign wr_en   = wv;
   assign wr_addr = wv ? wa : '0;
   assign dout    = wv ? sum : '0;
   assign last    = wv && !early;
`endif

   // last: the write issuing this cycle is the final one in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
               end
            end
            READ: begin
               if (rd_addr == AW'(N - 1)) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_addr <= rd_addr + AW'(1);
               end
            end
            DRAIN: begin
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               rd_addr <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Directed bench for poly_add_ctrl: RAM models for A/B/destination, timing and data checks.
// With POLY_ADD_OUT_REG_EN defined the bench runs the DUT at RD_LAT=2 with the registered output.
module tb_poly_add_ctrl;

   localparam int N = 1024;
   localparam int Q = 12289;
`ifdef POLY_ADD_OUT_REG_EN
   localparam int RDL  = 2;
   localparam int OREG = 1;
`else
   localparam int RDL  = 1;
   localparam int OREG = 0;
`endif
   localparam int LAT = 1 + RDL + OREG;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, rd_en, wr_en;
   logic [9:0]  rd_addr, wr_addr;
   logic [15:0] dia, dib, dout;

   poly_add_ctrl #(.N(N), .Q(Q), .AW(10), .RD_LAT(RDL)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_en   (rd_en),
      .dia     (dia),
      .dib     (dib),
      .wr_addr (wr_addr),
      .wr_en   (wr_en),
      .dout    (dout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit inplace = 1'b0;

   logic [15:0] ram_a [N];
   logic [15:0] ram_b [N];
   logic [15:0] ram_d [N];
   logic [15:0] exp_d [N];
   logic [15:0] qa [2];
   logic [15:0] qb [2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rd_en) begin
         qa[0] <= ram_a[rd_addr];
         qb[0] <= ram_b[rd_addr];
      end
      qa[1] <= qa[0];
      qb[1] <= qb[0];
      if (wr_en) begin
         if (inplace) ram_a[wr_addr] <= dout;
         else         ram_d[wr_addr] <= dout;
      end
   end

   assign dia = (RDL == 2) ? qa[1] : qa[0];
   assign dib = (RDL == 2) ? qb[1] : qb[0];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic fill(input int mode);
      int a, b, e;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: begin a = 0;     b = 0;     e = 0;     end
            1: begin a = 6144;  b = 6145;  e = 0;     end
            2: begin a = 12288; b = 1;     e = 0;     end
            3: begin a = 12288; b = 12288; e = 12287; end
            4: begin a = i;     b = 2 * i; e = (3 * i) % Q; end
            default: begin
               a = (i * 7) % Q;
               b = (Q - 1) - a + (i % 2);
               e = (i % 2) ? 0 : Q - 1;
            end
         endcase
         ram_a[i] = 16'(a);
         ram_b[i] = 16'(b);
         exp_d[i] = 16'(e);
         ram_d[i] = 16'hdead;
      end
   endtask

   task automatic run_op(input string tag, input int p1, input int p2, input int rst_at);
      int  n_wr = 0, wr_bad = 0, dat_bad = 0, done_cnt = 0, done_bad = 0, busy_bad = 0;
      int  mem_bad = 0, quiet_bad = 0;
      bit  aborted = 1'b0;
      bit  busy_exp;
      @(negedge clk);
      start = 1'b1;
      for (int rel = 1; rel <= N + LAT + 4; rel++) begin
         @(negedge clk);
         start = (rel == p1) || (rel == p2);
         if (rst_at > 0 && rel == rst_at + 1) begin
            chk({tag, "_rst_wr_en"}, 32'(wr_en), 0);
            chk({tag, "_rst_busy"},  32'(busy),  0);
            chk({tag, "_rst_done"},  32'(done),  0);
            rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (wr_en) begin
            if (wr_addr !== 10'(n_wr) || rel != LAT + n_wr) wr_bad++;
            if (n_wr < N && dout !== exp_d[n_wr]) dat_bad++;
            n_wr++;
         end
         if (done) begin
            done_cnt++;
            if (rel != N + LAT) done_bad++;
         end
         busy_exp = (rel <= N + LAT - 1);
         if (busy !== busy_exp) busy_bad++;
         if (rel == rst_at) rst = 1'b1;
      end
      start = 1'b0;
      if (aborted) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_en || busy || done) quiet_bad++;
         end
         chk({tag, "_quiet"}, 32'(quiet_bad), 0);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (inplace) begin
               if (ram_a[i] !== exp_d[i]) mem_bad++;
            end else begin
               if (ram_d[i] !== exp_d[i]) mem_bad++;
            end
         end
         chk({tag, "_nwr"},      32'(n_wr),     32'(N));
         chk({tag, "_wr_order"}, 32'(wr_bad),   0);
         chk({tag, "_data"},     32'(dat_bad),  0);
         chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
         chk({tag, "_done_cyc"}, 32'(done_bad), 0);
         chk({tag, "_busy"},     32'(busy_bad), 0);
         chk({tag, "_mem"},      32'(mem_bad),  0);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",    32'(busy),    0);
      chk("reset_done",    32'(done),    0);
      chk("reset_rd_en",   32'(rd_en),   0);
      chk("reset_wr_en",   32'(wr_en),   0);
      chk("reset_rd_addr", 32'(rd_addr), 0);
      chk("reset_wr_addr", 32'(wr_addr), 0);
      chk("reset_dout",    32'(dout),    0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      fill(0); run_op("zero",     -1, -1, -1);
      fill(1); run_op("sum_eq_q", -1, -1, -1);
      fill(2); run_op("a_qm1_b1", -1, -1, -1);
      fill(3); run_op("both_qm1", -1, -1, -1);
      fill(4); run_op("ramp_restart", 500, N + LAT, -1);
      fill(4); run_op("abort", -1, -1, 300);
      fill(4); run_op("after_abort", -1, -1, -1);
      fill(5);
      inplace = 1'b1;
      run_op("inplace", -1, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
